vram_row_engine: RTL

- Hardware row-fill/scroll engine and port-A arbiter for the text VRAM (80x30 glyphs, 2 glyphs per 32-bit word, 40 words per row, 1200 words).
- Sits between the Avalon-MM slave and VRAM port A. Lets software clear playfield rows and collapse rows after a line clear without 40-word CPU loops.
- The host always has priority. The engine uses port A only on cycles the host leaves idle.

---
 rtl/vram_row_engine.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/vram_row_engine.sv
// Row-fill / scroll-down engine for the text VRAM, sharing port A with the host.
// The host always wins port A; the engine only advances on cycles the host leaves idle.
module vram_row_engine #(
  parameter int WORDS_PER_ROW = 40,
  parameter int NUM_ROWS      = 30,
  parameter int AW            = 11
) (
  input  logic          CLK,
  input  logic          RESET_N,
  input  logic          HOST_READ,
  input  logic          HOST_WRITE,
  input  logic [AW-1:0] HOST_ADDR,
  input  logic [3:0]    HOST_BYTE_EN,
  input  logic [31:0]   HOST_WRITEDATA,
  input  logic          CMD_VALID,
  output logic          CMD_READY,
  input  logic [1:0]    CMD_OP,
  input  logic [4:0]    CMD_TOP,
  input  logic [4:0]    CMD_BOT,
  input  logic [31:0]   CMD_FILL,
  output logic          BUSY,
  output logic          DONE,
  output logic          ERR,
  output logic [AW-1:0] RAM_ADDR,
  output logic [3:0]    RAM_BYTE_EN,
  output logic [31:0]   RAM_WDATA,
  output logic          RAM_WREN,
  output logic          RAM_RDEN,
  input  logic [31:0]   RAM_Q
);

  typedef enum logic [2:0] {
    S_IDLE, S_REJ, S_FILL, S_SRD, S_SWR, S_FIN
  } state_t;

  state_t        state;
  logic [AW-1:0] addr_r;
  logic [AW-1:0] end_r;
  logic [4:0]    top_r;
  logic [31:0]   fill_r;
  logic [31:0]   hold_p1;
  logic          rd_vld_p1;
  logic          host_act;
  logic          grant;
  logic          bad_cmd;

  function automatic logic [AW-1:0] row_base(input logic [4:0] row);
    return AW'(row) * AW'(WORDS_PER_ROW);
  endfunction

  function automatic logic [AW-1:0] row_last(input logic [4:0] row);
    return row_base(row) + AW'(WORDS_PER_ROW - 1);
  endfunction

  assign host_act = HOST_READ | HOST_WRITE;
  assign grant    = ~host_act;
  assign bad_cmd  = CMD_OP[1] | (CMD_TOP > CMD_BOT) | (int'(CMD_BOT) >= NUM_ROWS);

  // Port A mux: host passthrough, otherwise the engine request for the current state
  always_comb begin
    RAM_ADDR    = addr_r;
    RAM_BYTE_EN = 4'hF;
    RAM_WDATA   = fill_r;
    RAM_WREN    = 1'b0;
    RAM_RDEN    = 1'b0;
    if (host_act) begin
      RAM_ADDR    = HOST_ADDR;
      RAM_BYTE_EN = HOST_BYTE_EN;
      RAM_WDATA   = HOST_WRITEDATA;
      RAM_WREN    = HOST_WRITE;
      RAM_RDEN    = HOST_READ;
    end else begin
      case (state)
        S_FILL: RAM_WREN = 1'b1;
        S_SRD: begin
          RAM_RDEN = 1'b1;
          RAM_ADDR = addr_r - AW'(WORDS_PER_ROW);
        end
        S_SWR: begin
          RAM_WREN  = 1'b1;
          // Write straight from RAM_Q when it arrives this cycle; hold_p1 only captures it at the edge
          RAM_WDATA = rd_vld_p1 ? RAM_Q : hold_p1;
        end
        default: ;
      endcase
    end
  end

  // Read-data stage: RAM_Q is captured the cycle after every granted engine read
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      rd_vld_p1 <= 1'b0;
      hold_p1   <= '0;
    end else begin
      rd_vld_p1 <= (state == S_SRD) && grant;
      if (rd_vld_p1) hold_p1 <= RAM_Q;
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state     <= S_IDLE;
      CMD_READY <= 1'b1;
      BUSY      <= 1'b0;
      DONE      <= 1'b0;
      ERR       <= 1'b0;
      addr_r    <= '0;
      end_r     <= '0;
      top_r     <= '0;
      fill_r    <= '0;
    end else begin
      DONE <= 1'b0;
      ERR  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (CMD_VALID && CMD_READY) begin
            CMD_READY <= 1'b0;
            fill_r    <= CMD_FILL;
            top_r     <= CMD_TOP;
            if (bad_cmd) begin
              ERR   <= 1'b1;
              state <= S_REJ;
            end else begin
              BUSY <= 1'b1;
              if (CMD_OP[0] && (CMD_TOP != CMD_BOT)) begin
                // Copy descends from the last word of BOT so sources are read before being overwritten
                addr_r <= row_last(CMD_BOT);
                end_r  <= row_base(CMD_TOP) + AW'(WORDS_PER_ROW);
                state  <= S_SRD;
              end else begin
                addr_r <= row_base(CMD_TOP);
                end_r  <= CMD_OP[0] ? row_last(CMD_TOP) : row_last(CMD_BOT);
                state  <= S_FILL;
              end
            end
          end
        end
        S_REJ: begin
          CMD_READY <= 1'b1;
          state     <= S_IDLE;
        end
        S_FILL: begin
          if (grant) begin
            if (addr_r == end_r) state <= S_FIN;
            else addr_r <= addr_r + AW'(1);
          end
        end
        S_SRD: begin
          if (grant) state <= S_SWR;
        end
        S_SWR: begin
          if (grant) begin
            if (addr_r == end_r) begin
              addr_r <= row_base(top_r);
              end_r  <= row_last(top_r);
              state  <= S_FILL;
            end else begin
              addr_r <= addr_r - AW'(1);
              state  <= S_SRD;
            end
          end
        end
        S_FIN: begin
          DONE      <= 1'b1;
          BUSY      <= 1'b0;
          CMD_READY <= 1'b1;
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
